elevator_car_ctrl: RTL

//   Consumes the move_clk tick stream from the move-frequency generator and the

---
 rtl/elevator_car_ctrl_if.sv | 24 ++
 rtl/elevator_car_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_ctrl_if.sv
// Elevator car controller signal bundle: floor buttons and move tick in,
// car status out to the move generator and display logic.
interface elevator_car_ctrl_if;
  logic       button1;
  logic       button2;
  logic       button3;
  logic       move_clk;
  logic       moving;
  logic       dir_up;
  logic [1:0] floor;
  logic       door_open;
  logic [2:0] pending;
  logic       arrived;

  modport master (
    output button1, button2, button3, move_clk,
    input  moving, dir_up, floor, door_open, pending, arrived
  );

  modport slave (
    input  button1, button2, button3, move_clk,
    output moving, dir_up, floor, door_open, pending, arrived
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: latches active-low floor calls, picks a travel
// direction and steps the car one floor per TICKS_PER_FLOOR move_clk ticks,
// holding the door open for DOOR_TICKS ticks at each requested floor.
module elevator_car_ctrl #(
  parameter int TICKS_PER_FLOOR = 4,
  parameter int DOOR_TICKS      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  elevator_car_ctrl_if.slave  bus
);

  localparam int MOVE_LIM = (TICKS_PER_FLOOR > 2) ? TICKS_PER_FLOOR : 2;
  localparam int DOOR_LIM = (DOOR_TICKS > 2) ? DOOR_TICKS : 2;
  localparam int MCW      = $clog2(MOVE_LIM) + 1;
  localparam int DCW      = $clog2(DOOR_LIM) + 1;
  localparam logic [MCW-1:0] MOVE_LAST = MCW'(TICKS_PER_FLOOR - 1);
  localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     floor_q, floor_d;
  logic           dir_up_q, dir_up_d;
  logic [2:0]     pending_q, pending_d;
  logic [MCW-1:0] move_cnt_q, move_cnt_d;
  logic [DCW-1:0] door_cnt_q, door_cnt_d;
  logic           arrived_q, arrived_d;

  logic [2:0]     btn_s1, btn_s2, btn_prev;
  logic           mc_s1, mc_s2, mc_prev;
  logic [2:0]     press;
  logic           tick;

  logic [2:0]     press_eff;
  logic [2:0]     clear;
  logic [1:0]     step_floor;
  logic           req_above, req_below;

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= '1;
      btn_s2   <= '1;
      btn_prev <= '1;
      mc_s1    <= 1'b1;
      mc_s2    <= 1'b1;
      mc_prev  <= 1'b1;
    end else begin
      btn_s1   <= {bus.button3, bus.button2, bus.button1};
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      mc_s1    <= bus.move_clk;
      mc_s2    <= mc_s1;
      mc_prev  <= mc_s2;
    end
  end

  assign press = btn_prev & ~btn_s2;
  assign tick  = mc_s2 & ~mc_prev;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Position, direction, request and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      floor_q    <= 2'd0;
      dir_up_q   <= 1'b1;
      pending_q  <= '0;
      move_cnt_q <= '0;
      door_cnt_q <= '0;
      arrived_q  <= 1'b0;
    end else begin
      floor_q    <= floor_d;
      dir_up_q   <= dir_up_d;
      pending_q  <= pending_d;
      move_cnt_q <= move_cnt_d;
      door_cnt_q <= door_cnt_d;
      arrived_q  <= arrived_d;
    end
  end

  // Next-state: direction choice, floor stepping, door timing, request latch.
  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_up_d   = dir_up_q;
    move_cnt_d = move_cnt_q;
    door_cnt_d = door_cnt_q;
    arrived_d  = 1'b0;
    clear      = '0;
    step_floor = dir_up_q ? (floor_q + 2'd1) : (floor_q - 2'd1);

    case (floor_q)
      2'd0: begin
        req_above = |pending_q[2:1];
        req_below = 1'b0;
      end
      2'd1: begin
        req_above = pending_q[2];
        req_below = pending_q[0];
      end
      default: begin
        req_above = 1'b0;
        req_below = |pending_q[1:0];
      end
    endcase

    unique case (state_q)
      IDLE: begin
        // Counters held at zero so ticks seen while idle never accumulate.
        move_cnt_d = '0;
        door_cnt_d = '0;
        if (pending_q[floor_q]) begin
          state_d        = DOOR;
          clear[floor_q] = 1'b1;
          arrived_d      = 1'b1;
        end else if (req_above && (dir_up_q || !req_below)) begin
          state_d  = MOVE;
          dir_up_d = 1'b1;
        end else if (req_below) begin
          state_d  = MOVE;
          dir_up_d = 1'b0;
        end
      end
      MOVE: begin
        if (tick) begin
          if (move_cnt_q == MOVE_LAST) begin
            // Floor step and the stop decision for the new floor share one clk.
            move_cnt_d = '0;
            floor_d    = step_floor;
            if (pending_q[step_floor]) begin
              state_d           = DOOR;
              clear[step_floor] = 1'b1;
              arrived_d         = 1'b1;
            end else if ((step_floor == 2'd0) || (step_floor == 2'd2)) begin
              state_d = IDLE;
            end
          end else begin
            move_cnt_d = move_cnt_q + MCW'(1);
          end
        end
      end
      DOOR: begin
        if (tick) begin
          if (door_cnt_q == DOOR_LAST) begin
            door_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            door_cnt_d = door_cnt_q + DCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Calls for the floor whose door is open are dropped; clearing beats
    // a simultaneous press of the same bit.
    press_eff = press;
    if (state_q == DOOR) begin
      press_eff[floor_q] = 1'b0;
    end
    pending_d = (pending_q | press_eff) & ~clear;
  end

  // Outputs, all decoded from registered state.
  always_comb begin
    bus.moving    = (state_q == MOVE);
    bus.door_open = (state_q == DOOR);
    bus.dir_up    = dir_up_q;
    bus.floor     = floor_q;
    bus.pending   = pending_q;
    bus.arrived   = arrived_q;
  end

endmodule
